fighter_fsm: RTL and testbench



---
 rtl/fighter_fsm.sv | 194 +++++++++++++++++++
 tb/tb_fighter_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_fsm.sv
// Per-player fighter controller: movement, neutral/directional attacks, hit/block stun.
// All outputs registered; state advances only on frame_tick, holding otherwise.
module fighter_fsm #(
  parameter int FACING_LEFT = 1,
  parameter int SCREEN_W    = 640,
  parameter int SPRITE_W    = 64,
  parameter int X_INIT      = 566,
  parameter int FWD_STEP    = 3,
  parameter int BWD_STEP    = 2,
  parameter int N_SU        = 3,
  parameter int N_ACT       = 2,
  parameter int N_REC       = 14,
  parameter int D_SU        = 4,
  parameter int D_ACT       = 3,
  parameter int D_REC       = 15,
  parameter int HITSTUN_T   = 15,
  parameter int BLOCKSTUN_T = 10,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_attack,
  input  logic             hit_in,
  input  logic [9:0]       x_pos_opponent,
  output logic [9:0]       x_pos,
  output logic [3:0]       state,
  output logic             attacking,
  output logic             dir_attacking,
  output logic             hitbox_active,
  output logic [CNT_W-1:0] attack_frame
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FWD       = 4'd1,
    BWD       = 4'd2,
    ATK_SU    = 4'd3,
    ATK_ACT   = 4'd4,
    ATK_REC   = 4'd5,
    HITSTUN   = 4'd6,
    BLOCKSTUN = 4'd7
  } state_t;

  localparam logic [CNT_W-1:0] N_SU_LAST  = CNT_W'(N_SU - 1);
  localparam logic [CNT_W-1:0] N_ACT_LAST = CNT_W'(N_ACT - 1);
  localparam logic [CNT_W-1:0] N_REC_LAST = CNT_W'(N_REC - 1);
  localparam logic [CNT_W-1:0] D_SU_LAST  = CNT_W'(D_SU - 1);
  localparam logic [CNT_W-1:0] D_ACT_LAST = CNT_W'(D_ACT - 1);
  localparam logic [CNT_W-1:0] D_REC_LAST = CNT_W'(D_REC - 1);
  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HITSTUN_T - 1);
  localparam logic [CNT_W-1:0] BLK_LAST   = CNT_W'(BLOCKSTUN_T - 1);

  localparam logic signed [11:0] FWD_S   = 12'(FWD_STEP);
  localparam logic signed [11:0] BWD_S   = 12'(BWD_STEP);
  localparam logic signed [11:0] SPR_S   = 12'(SPRITE_W);
  localparam logic signed [11:0] X_MAX_S = 12'(SCREEN_W - SPRITE_W);

  state_t           st;
  logic [CNT_W-1:0] cnt;

  assign state        = st;
  assign attack_frame = cnt;

  logic fwd_btn, bwd_btn, fwd, bwd;
  assign fwd_btn = (FACING_LEFT != 0) ? btn_left  : btn_right;
  assign bwd_btn = (FACING_LEFT != 0) ? btn_right : btn_left;
  assign fwd     = fwd_btn & ~bwd_btn;
  assign bwd     = bwd_btn & ~fwd_btn;

  logic [CNT_W-1:0] su_last, act_last, rec_last;
  assign su_last  = attacking ? N_SU_LAST  : D_SU_LAST;
  assign act_last = attacking ? N_ACT_LAST : D_ACT_LAST;
  assign rec_last = attacking ? N_REC_LAST : D_REC_LAST;

  function automatic logic [9:0] sat10(input logic signed [11:0] v);
    if (v < 12'sd0)         return 10'd0;
    else if (v > 12'sd1023) return 10'd1023;
    else                    return v[9:0];
  endfunction

  // Signed 12-bit headroom so underflow below 0 and the opponent limit never wrap.
  logic signed [11:0] x_s, opp_s, fwd_raw, fwd_lim, bwd_raw, fwd_sel, bwd_sel;
  logic [9:0]         fwd_x, bwd_x;

  always_comb begin
    x_s   = signed'({2'b00, x_pos});
    opp_s = signed'({2'b00, x_pos_opponent});
    if (FACING_LEFT != 0) begin
      fwd_raw = x_s - FWD_S;
      fwd_lim = opp_s + SPR_S;
      fwd_sel = (fwd_raw > fwd_lim) ? fwd_raw : fwd_lim;
      bwd_raw = x_s + BWD_S;
      bwd_sel = (bwd_raw < X_MAX_S) ? bwd_raw : X_MAX_S;
    end else begin
      fwd_raw = x_s + FWD_S;
      fwd_lim = opp_s - SPR_S;
      fwd_sel = (fwd_raw < fwd_lim) ? fwd_raw : fwd_lim;
      bwd_raw = x_s - BWD_S;
      bwd_sel = (bwd_raw > 12'sd0) ? bwd_raw : 12'sd0;
    end
    fwd_x = sat10(fwd_sel);
    bwd_x = sat10(bwd_sel);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st            <= IDLE;
      x_pos         <= 10'(X_INIT);
      attacking     <= 1'b0;
      dir_attacking <= 1'b0;
      hitbox_active <= 1'b0;
      cnt           <= '0;
    end else if (frame_tick) begin
      hitbox_active <= 1'b0;
      if (hit_in) begin
        st            <= (st == BWD) ? BLOCKSTUN : HITSTUN;
        cnt           <= '0;
        attacking     <= 1'b0;
        dir_attacking <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (btn_attack) begin
              st        <= ATK_SU;
              attacking <= 1'b1;
              cnt       <= '0;
            end else if (fwd) st <= FWD;
            else if (bwd)     st <= BWD;
          end
          FWD: begin
            if (btn_attack) begin
              st            <= ATK_SU;
              dir_attacking <= 1'b1;
              cnt           <= '0;
            end else if (fwd) x_pos <= fwd_x;
            else              st    <= IDLE;
          end
          BWD: begin
            if (btn_attack) begin
              st            <= ATK_SU;
              dir_attacking <= 1'b1;
              cnt           <= '0;
            end else if (bwd) x_pos <= bwd_x;
            else              st    <= IDLE;
          end
          ATK_SU: begin
            if (cnt == su_last) begin
              st            <= ATK_ACT;
              cnt           <= '0;
              hitbox_active <= 1'b1;
            end else cnt <= cnt + 1'b1;
          end
          ATK_ACT: begin
            if (cnt == act_last) begin
              st  <= ATK_REC;
              cnt <= '0;
            end else begin
              cnt           <= cnt + 1'b1;
              hitbox_active <= 1'b1;
            end
          end
          ATK_REC: begin
            if (cnt == rec_last) begin
              st            <= IDLE;
              cnt           <= '0;
              attacking     <= 1'b0;
              dir_attacking <= 1'b0;
            end else cnt <= cnt + 1'b1;
          end
          HITSTUN: begin
            if (cnt == HIT_LAST) begin
              st  <= IDLE;
              cnt <= '0;
            end else cnt <= cnt + 1'b1;
          end
          BLOCKSTUN: begin
            if (cnt == BLK_LAST) begin
              st  <= IDLE;
              cnt <= '0;
            end else cnt <= cnt + 1'b1;
          end
          default: begin
            st  <= IDLE;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fighter_fsm.sv
// Directed bench for fighter_fsm: attacks, clamps, stuns, enable gating and async reset.
module tb_fighter_fsm;
  logic clk = 1'b0;
  logic reset_n, frame_tick, btn_left, btn_right, btn_attack, hit_in;
  logic [9:0] opp_a, opp_fc, opp_bc, opp_r;

  logic [9:0] x_a, x_fc, x_bc, x_r;
  logic [3:0] st_a, st_fc, st_bc, st_r;
  logic atk_a, atk_fc, atk_bc, atk_r;
  logic dir_a, dir_fc, dir_bc, dir_r;
  logic hb_a, hb_fc, hb_bc, hb_r;
  logic [4:0] fr_a, fr_fc, fr_bc, fr_r;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fighter_fsm dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .hit_in(hit_in), .x_pos_opponent(opp_a), .x_pos(x_a), .state(st_a),
    .attacking(atk_a), .dir_attacking(dir_a), .hitbox_active(hb_a),
    .attack_frame(fr_a));

  fighter_fsm #(.X_INIT(130)) dut_fc (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .hit_in(hit_in), .x_pos_opponent(opp_fc), .x_pos(x_fc), .state(st_fc),
    .attacking(atk_fc), .dir_attacking(dir_fc), .hitbox_active(hb_fc),
    .attack_frame(fr_fc));

  fighter_fsm #(.X_INIT(575)) dut_bc (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .hit_in(hit_in), .x_pos_opponent(opp_bc), .x_pos(x_bc), .state(st_bc),
    .attacking(atk_bc), .dir_attacking(dir_bc), .hitbox_active(hb_bc),
    .attack_frame(fr_bc));

  fighter_fsm #(.FACING_LEFT(0), .X_INIT(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .hit_in(hit_in), .x_pos_opponent(opp_r), .x_pos(x_r), .state(st_r),
    .attacking(atk_r), .dir_attacking(dir_r), .hitbox_active(hb_r),
    .attack_frame(fr_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    btn_left = 0; btn_right = 0; btn_attack = 0; hit_in = 0; frame_tick = 0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; frame_tick = 0; btn_left = 0; btn_right = 0; btn_attack = 0; hit_in = 0;
    opp_a = 10'd0; opp_fc = 10'd64; opp_bc = 10'd0; opp_r = 10'd1000;
    #12;
    chk("rst_state", 32'(st_a), 0);
    chk("rst_x", 32'(x_a), 566);
    chk("rst_atk", 32'(atk_a), 0);
    chk("rst_dir", 32'(dir_a), 0);
    chk("rst_hb", 32'(hb_a), 0);
    chk("rst_frame", 32'(fr_a), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Neutral attack 3/2/14
    btn_attack = 1; tick(); btn_attack = 0;
    chk("n_su0_state", 32'(st_a), 3);
    chk("n_su0_atk", 32'(atk_a), 1);
    chk("n_su0_frame", 32'(fr_a), 0);
    tick(); chk("n_su1_frame", 32'(fr_a), 1);
    tick(); chk("n_su2_frame", 32'(fr_a), 2); chk("n_su2_state", 32'(st_a), 3);
    tick(); chk("n_act0_state", 32'(st_a), 4); chk("n_act0_hb", 32'(hb_a), 1);
    chk("n_act0_frame", 32'(fr_a), 0);
    tick(); chk("n_act1_state", 32'(st_a), 4); chk("n_act1_hb", 32'(hb_a), 1);
    chk("n_act1_frame", 32'(fr_a), 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("n_rec_state", 32'(st_a), 5);
      chk("n_rec_frame", 32'(fr_a), 32'(i));
      chk("n_rec_atk", 32'(atk_a), 1);
      chk("n_rec_hb", 32'(hb_a), 0);
    end
    tick(); chk("n_end_state", 32'(st_a), 0); chk("n_end_atk", 32'(atk_a), 0);
    chk("n_end_frame", 32'(fr_a), 0);

    // Directional attack: forward 5 ticks then attack
    btn_left = 1;
    tick(); chk("d_fwd_entry_state", 32'(st_a), 1); chk("d_fwd_entry_x", 32'(x_a), 566);
    tick(); chk("d_x1", 32'(x_a), 563);
    tick(); chk("d_x2", 32'(x_a), 560);
    tick(); chk("d_x3", 32'(x_a), 557);
    tick(); chk("d_x4", 32'(x_a), 554);
    btn_attack = 1; tick(); btn_attack = 0;
    chk("d_su0_state", 32'(st_a), 3); chk("d_su0_dir", 32'(dir_a), 1);
    chk("d_su0_atk", 32'(atk_a), 0); chk("d_su0_x", 32'(x_a), 554);
    tick(); tick(); tick();
    chk("d_su3_state", 32'(st_a), 3); chk("d_su3_frame", 32'(fr_a), 3);
    chk("d_su3_x", 32'(x_a), 554);
    btn_left = 0;
    tick(); chk("d_act0_state", 32'(st_a), 4); chk("d_act0_hb", 32'(hb_a), 1);
    tick(); tick();
    chk("d_act2_state", 32'(st_a), 4); chk("d_act2_frame", 32'(fr_a), 2);
    chk("d_act2_hb", 32'(hb_a), 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("d_rec_state", 32'(st_a), 5);
      chk("d_rec_frame", 32'(fr_a), 32'(i));
      chk("d_rec_dir", 32'(dir_a), 1);
    end
    chk("d_rec_x", 32'(x_a), 554);
    tick(); chk("d_end_state", 32'(st_a), 0); chk("d_end_dir", 32'(dir_a), 0);
    chk("d_end_x", 32'(x_a), 554);

    // Enable gating mid-attack, then async reset mid-recovery
    btn_attack = 1; tick(); btn_attack = 0;
    tick(); tick(); tick();
    chk("g_act0_state", 32'(st_a), 4);
    hit_in = 1; btn_left = 1; btn_attack = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("g_hold_state", 32'(st_a), 4); chk("g_hold_frame", 32'(fr_a), 0);
    chk("g_hold_hb", 32'(hb_a), 1); chk("g_hold_atk", 32'(atk_a), 1);
    chk("g_hold_x", 32'(x_a), 554);
    hit_in = 0; btn_left = 0; btn_attack = 0;
    tick(); chk("g_act1_frame", 32'(fr_a), 1);
    tick(); tick(); chk("g_rec1_state", 32'(st_a), 5); chk("g_rec1_frame", 32'(fr_a), 1);
    reset_n = 1'b0;
    #2;
    chk("ar_state", 32'(st_a), 0); chk("ar_x", 32'(x_a), 566);
    chk("ar_atk", 32'(atk_a), 0); chk("ar_frame", 32'(fr_a), 0);
    chk("ar_hb", 32'(hb_a), 0);
    do_reset();

    // Hit while walking backward -> blockstun 10
    btn_right = 1;
    tick(); chk("b_entry_state", 32'(st_a), 2);
    tick(); chk("b_x", 32'(x_a), 568);
    hit_in = 1; tick(); hit_in = 0; btn_right = 0;
    chk("bs0_state", 32'(st_a), 7); chk("bs0_frame", 32'(fr_a), 0);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("bs_state", 32'(st_a), 7);
      chk("bs_frame", 32'(fr_a), 32'(i));
    end
    tick(); chk("bs_end_state", 32'(st_a), 0); chk("bs_end_x", 32'(x_a), 568);

    // Hit during active phase -> hitstun, re-hit at stun tick 7 restarts
    btn_attack = 1; tick(); btn_attack = 0;
    tick(); tick(); tick();
    chk("h_act_state", 32'(st_a), 4);
    hit_in = 1; tick(); hit_in = 0;
    chk("hs0_state", 32'(st_a), 6); chk("hs0_atk", 32'(atk_a), 0);
    chk("hs0_hb", 32'(hb_a), 0); chk("hs0_frame", 32'(fr_a), 0);
    for (int i = 1; i < 7; i++) begin
      tick();
      chk("hs_frame", 32'(fr_a), 32'(i));
    end
    hit_in = 1; tick(); hit_in = 0;
    chk("hs_rehit_state", 32'(st_a), 6); chk("hs_rehit_frame", 32'(fr_a), 0);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("hs2_state", 32'(st_a), 6);
      chk("hs2_frame", 32'(fr_a), 32'(i));
    end
    tick(); chk("hs_end_state", 32'(st_a), 0);

    // hit_in beats btn_attack
    hit_in = 1; btn_attack = 1; tick(); hit_in = 0; btn_attack = 0;
    chk("hp_state", 32'(st_a), 6); chk("hp_atk", 32'(atk_a), 0);

    // Forward clamp against opponent, then both buttons -> idle
    do_reset();
    btn_left = 1;
    tick(); chk("fc_entry_x", 32'(x_fc), 130); chk("fc_entry_state", 32'(st_fc), 1);
    tick(); chk("fc_x1", 32'(x_fc), 128);
    tick(); chk("fc_x2", 32'(x_fc), 128);
    btn_right = 1;
    tick(); chk("fc_both_state", 32'(st_fc), 0); chk("fc_both_x", 32'(x_fc), 128);

    // Backward clamp at right screen edge (facing left)
    do_reset();
    btn_right = 1;
    tick(); chk("bc_entry_state", 32'(st_bc), 2); chk("bc_entry_x", 32'(x_bc), 575);
    tick(); chk("bc_x1", 32'(x_bc), 576);
    tick(); chk("bc_x2", 32'(x_bc), 576);

    // Backward clamp at left edge (facing right), no wrap
    do_reset();
    btn_left = 1;
    tick(); chk("r_entry_state", 32'(st_r), 2); chk("r_entry_x", 32'(x_r), 1);
    tick(); chk("r_x1", 32'(x_r), 0);
    tick(); chk("r_x2", 32'(x_r), 0);
    btn_left = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
